fwft_sync_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO buffering a stream between a producer and a consumer. The head word is always presented on dout while empty is low, and rd_en acknowledges/pops it; no read-request latency. It is intended for block transfers where producer and consumer run at independent, bursty rates.

---
 rtl/fwft_sync_fifo_if.sv | 14 +
 rtl/fwft_sync_fifo.sv | 56 +++++
 tb/tb_fwft_sync_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fwft_sync_fifo_if.sv
// fwft_sync_fifo_if: producer/consumer handshake bundle for the FWFT FIFO
interface fwft_sync_fifo_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  full;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_en;
    logic                  empty;

    modport master (output din, wr_en, rd_en, input full, dout, empty);
    modport slave  (input din, wr_en, rd_en, output full, dout, empty);
endinterface

// File: rtl/fwft_sync_fifo.sv
// fwft_sync_fifo: single-clock first-word-fall-through FIFO, circular memory feeding a registered output word
module fwft_sync_fifo #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 16
) (
    input logic             clk,
    input logic             rst,
    fwft_sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] r_wptr, r_rptr;
    logic [DEPTH_WIDTH:0]   r_mem_cnt, w_mem_cnt_nxt;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_valid, r_full;
    logic                   w_wr, w_rd, w_load, w_valid_nxt, w_full_nxt;

    // The output word only refills from words already in memory, giving the one-cycle fall-through.
    always_comb begin
        w_wr          = bus.wr_en & ~r_full;
        w_rd          = bus.rd_en & r_valid;
        w_load        = (~r_valid | w_rd) & (r_mem_cnt != '0);
        w_valid_nxt   = w_load | (r_valid & ~w_rd);
        w_mem_cnt_nxt = r_mem_cnt + (DEPTH_WIDTH+1)'(w_wr) - (DEPTH_WIDTH+1)'(w_load);
        w_full_nxt    = (w_mem_cnt_nxt + (DEPTH_WIDTH+1)'(w_valid_nxt)) == (DEPTH_WIDTH+1)'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (w_wr && !rst) r_mem[r_wptr] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_mem_cnt <= '0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + DEPTH_WIDTH'(1);
            if (w_load) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + DEPTH_WIDTH'(1);
            end
            r_mem_cnt <= w_mem_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_full    <= w_full_nxt;
        end
    end

    assign bus.dout  = r_dout;
    assign bus.empty = ~r_valid;
    assign bus.full  = r_full;
endmodule

// File: tb/tb_fwft_sync_fifo.sv
// tb_fwft_sync_fifo: randomized bench against a queue-level model of the FWFT FIFO
module tb_fwft_sync_fifo;
    localparam int CAP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fwft_sync_fifo_if #(.DATA_WIDTH(16)) bus ();

    fwft_sync_fifo #(.DEPTH_WIDTH(4), .DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q [$];
    logic        pres = 1'b0;
    logic        logging = 1'b0;
    logic [15:0] tx [$];
    logic [15:0] rx [$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: q holds every stored word; pres says whether its head is already visible on dout.
    task automatic tick();
        logic rd, wr;
        if (!rst && bus.rd_en && !bus.empty) rx.push_back(bus.dout);
        @(posedge clk);
        if (rst) begin
            q.delete();
            pres = 1'b0;
        end else begin
            rd = bus.rd_en && pres;
            wr = bus.wr_en && q.size() < CAP;
            if (rd) begin
                void'(q.pop_front());
                pres = 1'b0;
            end
            if (!pres && q.size() > 0) pres = 1'b1;
            if (wr) begin
                q.push_back(bus.din);
                if (logging) tx.push_back(bus.din);
            end
        end
        @(negedge clk);
        check("empty", 32'(bus.empty), 32'(!pres));
        check("full", 32'(bus.full), 32'(q.size() == CAP));
        if (pres) check("dout", 32'(bus.dout), 32'(q[0]));
    endtask

    task automatic drive(logic wr, logic rd, logic [15:0] d);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.din   = d;
        tick();
    endtask

    initial begin
        int cyc;
        int pw, pr;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 16'($urandom));
            check("rst_dout", 32'(bus.dout), 32'h0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        check("post_rst_dout", 32'(bus.dout), 32'h0);
        check("post_rst_empty", 32'(bus.empty), 32'h1);

        drive(1'b1, 1'b0, 16'hA5A5);
        check("lat_edgeN_empty", 32'(bus.empty), 32'h1);
        drive(1'b0, 1'b0, 16'h0);
        check("lat_edgeN1_dout", 32'(bus.dout), 32'hA5A5);
        check("lat_edgeN1_empty", 32'(bus.empty), 32'h0);
        drive(1'b0, 1'b1, 16'h0);
        check("lat_pop_empty", 32'(bus.empty), 32'h1);

        for (int i = 1; i <= 17; i++) drive(1'b1, 1'b0, 16'(i));
        check("fill_full", 32'(bus.full), 32'h1);
        rx.delete();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 16'h0);
        check("drain_count", 32'(rx.size()), 32'd16);
        for (int i = 0; i < rx.size(); i++) check("drain_word", 32'(rx[i]), 32'(i + 1));
        check("drain_empty", 32'(bus.empty), 32'h1);

        for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, 16'($urandom));
        check("refill_full", 32'(bus.full), 32'h1);
        drive(1'b1, 1'b1, 16'hBEEF);
        check("full_rw_full", 32'(bus.full), 32'h0);
        rx.delete();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 16'h0);
        check("full_rw_count", 32'(rx.size()), 32'd15);
        foreach (rx[i]) if (rx[i] == 16'hBEEF) check("beef_dropped", 32'(rx[i]), 32'h0);

        tx.delete();
        rx.delete();
        logging = 1'b1;
        cyc = 0;
        while (rx.size() < 128 && cyc < 5000) begin
            case (tx.size() / 32)
                0:       begin pw = 30;  pr = 70;  end
                1:       begin pw = 70;  pr = 30;  end
                2:       begin pw = 100; pr = 100; end
                default: begin pw = 100; pr = 30;  end
            endcase
            if (tx.size() >= 128) pr = 100;
            drive(tx.size() < 128 && $urandom_range(99) < pw,
                  $urandom_range(99) < pr, 16'($urandom));
            cyc++;
        end
        logging = 1'b0;
        check("stream_count", 32'(rx.size()), 32'd128);
        for (int i = 0; i < rx.size() && i < tx.size(); i++) check("stream_word", 32'(rx[i]), 32'(tx[i]));

        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 16'($urandom));
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'h5555);
        rst = 1'b0;
        check("midrst_empty", 32'(bus.empty), 32'h1);
        check("midrst_full", 32'(bus.full), 32'h0);
        rx.delete();
        drive(1'b1, 1'b0, 16'h1234);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0);
        check("midrst_count", 32'(rx.size()), 32'd1);
        if (rx.size() > 0) check("midrst_word", 32'(rx[0]), 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
